// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity modes, baud divisor
// and the parity-check helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4,
    BREAK = 3'd5
  } state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int UART_CLKS_115200 = 434;

  // Returns 1 when the received parity bit disagrees with the data bits.
  function automatic logic parity_bad(input logic [7:0] data, input logic par_bit,
                                      input logic odd);
    return par_bit != ((^data) ^ odd);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input pin.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, optional parity, one stop bit, with a
// one-byte output buffer and single-cycle error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_115200,
  parameter int PARITY       = PAR_NONE
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy,
  output state_e     state_dbg
);

  // Handshake: a byte transfers on any rising clk edge where rx_valid and
  // rx_ready are both 1; rx_data is held stable for as long as rx_valid is 1.

  localparam logic [15:0] HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_LOAD  = 16'(CLKS_PER_BIT - 1);
  localparam logic        ODD_PAR   = (PARITY == PAR_ODD);

  logic        rxs;
  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_bad_q, par_bad_d;
  logic [7:0]  rx_data_d;
  logic        rx_valid_d, frame_err_d, parity_err_d, overrun_d;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rxd),
    .q       (rxs)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      par_bad_q  <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      par_bad_q  <= par_bad_d;
      rx_data    <= rx_data_d;
      rx_valid   <= rx_valid_d;
      frame_err  <= frame_err_d;
      parity_err <= parity_err_d;
      overrun    <= overrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    par_bad_d    = par_bad_q;
    rx_data_d    = rx_data;
    rx_valid_d   = rx_valid;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    overrun_d    = 1'b0;

    if (rx_valid && rx_ready) rx_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          timer_d = HALF_LOAD;
        end
      end
      START: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 16'd1;
        end else if (!rxs) begin
          state_d   = DATA;
          timer_d   = BIT_LOAD;
          bit_idx_d = '0;
          par_bad_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 16'd1;
        end else begin
          shift_d   = {rxs, shift_q[7:1]};
          timer_d   = BIT_LOAD;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = (PARITY != PAR_NONE) ? PAR : STOP;
        end
      end
      PAR: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 16'd1;
        end else begin
          par_bad_d = parity_bad(shift_q, rxs, ODD_PAR);
          timer_d   = BIT_LOAD;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 16'd1;
        end else begin
          state_d = IDLE;
          if (!rxs) begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end else if (par_bad_q) begin
            parity_err_d = 1'b1;
          end else if (!rx_valid || rx_ready) begin
            // A simultaneous accept frees the buffer, so the new byte wins.
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end
      BREAK: begin
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule
